// File: rtl/pcs_rx_descrambler.sv
// pcs_rx_descrambler: 64-bit self-synchronous x^58+x^39+1 descrambler with
// a sync-header high-BER monitor. One cycle of latency, data/header/valid
// registered together.
// Optional build macro DESCRAMBLER_BYPASS_EN adds a bypass input that
// forwards data_in unchanged. The descrambler state keeps loading while
// bypass is set, so leaving bypass needs no resync.
module pcs_rx_descrambler #(
  parameter int DATA_WIDTH    = 64,
  parameter int WINDOW_CYCLES = 19531,
  parameter int BER_THRESH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef DESCRAMBLER_BYPASS_EN
  input  logic                  bypass,
`endif
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            sync_in,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            sync_out,
  output logic                  data_out_valid,
  output logic                  descr_synced,
  output logic                  hi_ber,
  output logic [7:0]            err_cnt
);

  localparam int SW  = 58;
  localparam int WCW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int ECW = $clog2(BER_THRESH + 1);

  logic [SW-1:0]         s_q;
  logic [DATA_WIDTH-1:0] tap39, tap58, descr, dout_d, dout_q;
  logic [1:0]            sync_q;
  logic                  vld_q, synced_q, hi_ber_q, hi_ber_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [WCW-1:0]        win_cnt_q, win_cnt_d;
  logic [ECW-1:0]        win_err_q, win_err_inc, win_err_d;
  logic                  hdr_err, win_end;

  // Taps 39 and 58 bits back; low bits reach into the previous block's state.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_tap
    if (i < 39) begin : g_t39s
      assign tap39[i] = s_q[i+19];
    end else begin : g_t39d
      assign tap39[i] = data_in[i-39];
    end
    if (i < SW) begin : g_t58s
      assign tap58[i] = s_q[i];
    end else begin : g_t58d
      assign tap58[i] = data_in[i-SW];
    end
  end

  assign descr = data_in ^ tap39 ^ tap58;

`ifdef DESCRAMBLER_BYPASS_EN
  assign dout_d = bypass ? data_in : descr;
`else
  assign dout_d = descr;
`endif

  // Header check and BER window next-state.
  always_comb begin
    hdr_err     = data_in_valid && (sync_in[1] == sync_in[0]);
    win_end     = (win_cnt_q == WCW'(WINDOW_CYCLES - 1));
    err_cnt_d   = (hdr_err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    win_err_inc = (hdr_err && win_err_q < ECW'(BER_THRESH)) ? win_err_q + 1'b1 : win_err_q;
    hi_ber_d    = hi_ber_q;
    win_err_d   = win_err_inc;
    win_cnt_d   = win_cnt_q + 1'b1;
    if (win_end) begin
      // Closing window decides hi_ber, including an error on its last cycle.
      hi_ber_d  = (win_err_inc >= ECW'(BER_THRESH));
      win_err_d = '0;
      win_cnt_d = '0;
    end else if (win_err_inc >= ECW'(BER_THRESH)) begin
      hi_ber_d  = 1'b1;
    end
  end

  // Datapath and descrambler state; state and outputs load only on valid blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= '0;
      dout_q   <= '0;
      sync_q   <= '0;
      vld_q    <= 1'b0;
      synced_q <= 1'b0;
    end else begin
      vld_q <= data_in_valid;
      if (data_in_valid) begin
        s_q      <= data_in[DATA_WIDTH-1 -: SW];
        dout_q   <= dout_d;
        sync_q   <= sync_in;
        synced_q <= 1'b1;
      end
    end
  end

  // BER monitor state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      hi_ber_q  <= hi_ber_d;
    end
  end

  assign data_out       = dout_q;
  assign sync_out       = sync_q;
  assign data_out_valid = vld_q;
  assign descr_synced   = synced_q;
  assign hi_ber         = hi_ber_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_pcs_rx_descrambler.sv
// Bench for pcs_rx_descrambler: serial bit-level reference descrambler feeds
// a scoreboard queue; a monitor pops and compares on every output valid.
module tb_pcs_rx_descrambler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_in = '0;
  logic [1:0]  sync_in = '0;
  logic        data_in_valid = 1'b0;
  logic [63:0] data_out;
  logic [1:0]  sync_out;
  logic        data_out_valid, descr_synced, hi_ber;
  logic [7:0]  err_cnt;
`ifdef DESCRAMBLER_BYPASS_EN
  logic        bypass = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  s;
  } exp_t;

  exp_t        sb[$];
  logic [57:0] msr;            // reference line history, bit 0 most recent
  logic [57:0] ssr;            // reference scrambler state
  logic [63:0] last_d;
  logic [1:0]  last_s;
  int          tests = 0;
  int          fails = 0;

  pcs_rx_descrambler #(.DATA_WIDTH(64), .WINDOW_CYCLES(64), .BER_THRESH(16)) dut (
    .clk(clk), .rst(rst),
`ifdef DESCRAMBLER_BYPASS_EN
    .bypass(bypass),
`endif
    .data_in(data_in), .sync_in(sync_in), .data_in_valid(data_in_valid),
    .data_out(data_out), .sync_out(sync_out), .data_out_valid(data_out_valid),
    .descr_synced(descr_synced), .hi_ber(hi_ber), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: pop on valid output, otherwise outputs must hold.
  initial begin
    exp_t e;
    last_d = '0;
    last_s = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_d = '0;
        last_s = '0;
      end else if (data_out_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: data_out=%h with empty scoreboard", data_out);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.d || sync_out !== e.s) begin
            fails++;
            $display("FAIL sb_data: got %h/%b expected %h/%b", data_out, sync_out, e.d, e.s);
          end
          last_d = e.d;
          last_s = e.s;
        end
      end else begin
        tests++;
        if (data_out !== last_d || sync_out !== last_s) begin
          fails++;
          $display("FAIL hold: got %h/%b expected %h/%b", data_out, sync_out, last_d, last_s);
        end
      end
    end
  end

  // Drive one cycle at a negedge; returns at the next negedge.
  task automatic put(input logic [63:0] d, input logic [1:0] s, input logic v,
                     input logic use_c, input logic [63:0] c);
    logic [63:0] m;
    exp_t e;
    m = '0;
    if (v) begin
      for (int i = 0; i < 64; i++) begin
        m[i] = d[i] ^ msr[38] ^ msr[57];
        msr  = {msr[56:0], d[i]};
      end
      e.d = use_c ? c : m;
      e.s = s;
      sb.push_back(e);
    end
    data_in = d;
    sync_in = s;
    data_in_valid = v;
    @(negedge clk);
    tests++;
    if (data_out_valid !== v) begin
      fails++;
      $display("FAIL valid_delay: data_out_valid=%b expected %b", data_out_valid, v);
    end
  endtask

  // Idle cycles carry an illegal header that must be ignored.
  task automatic idle(input int n);
    repeat (n) put(64'hDEAD_BEEF_0BAD_F00D, 2'b11, 1'b0, 1'b0, '0);
  endtask

  task automatic scramble(input logic [63:0] p, output logic [63:0] o);
    for (int i = 0; i < 64; i++) begin
      o[i] = p[i] ^ ssr[38] ^ ssr[57];
      ssr  = {ssr[56:0], o[i]};
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    data_in = '0;
    sync_in = '0;
    data_in_valid = 1'b0;
    sb.delete();
    msr = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    data_in_valid = 1'b0;
    sb.delete();
    msr = '0;
    #1;
    chk("rst_data_out", data_out, 64'h0);
    chk("rst_sync_out", {62'h0, sync_out}, 64'h0);
    chk("rst_valid", {63'h0, data_out_valid}, 64'h0);
    chk("rst_synced", {63'h0, descr_synced}, 64'h0);
    chk("rst_hi_ber", {63'h0, hi_ber}, 64'h0);
    chk("rst_err_cnt", {56'h0, err_cnt}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_block();
    do_reset();
    put(64'h0, 2'b01, 1'b1, 1'b1, 64'h0);
    chk("zero_synced", {63'h0, descr_synced}, 64'h1);
    chk("zero_err_cnt", {56'h0, err_cnt}, 64'h0);
    chk("zero_sync_out", {62'h0, sync_out}, 64'h1);
    idle(2);
  endtask

  task automatic test_single_bit();
    do_reset();
    put(64'h1, 2'b01, 1'b1, 1'b1, 64'h0400_0080_0000_0001);
    put(64'h0, 2'b10, 1'b1, 1'b1, 64'h0);
    idle(2);
  endtask

  task automatic test_round_trip();
    logic [63:0] p [3];
    logic [63:0] sc;
    p[0] = 64'h78d5555555555555;
    p[1] = 64'hbbaa554433221100;
    p[2] = 64'hcc713b28b2070707;
    do_reset();
    ssr = '1;
    for (int k = 0; k < 3; k++) begin
      scramble(p[k], sc);
      put(sc, (k == 1) ? 2'b01 : 2'b10, 1'b1, k > 0, p[k]);
      if (k == 1) idle(1);
    end
    // back-to-back random blocks checked against the serial reference
    for (int k = 0; k < 6; k++) begin
      put({$urandom, $urandom}, 2'b01, 1'b1, 1'b0, '0);
    end
    idle(2);
    chk("rt_sb_empty", 64'(sb.size()), 64'h0);
  endtask

  task automatic test_sync_errors();
    do_reset();
    repeat (15) put({$urandom, $urandom}, 2'b11, 1'b1, 1'b0, '0);
    idle(1);
    chk("se_hi_ber_15", {63'h0, hi_ber}, 64'h0);
    chk("se_err_cnt_15", {56'h0, err_cnt}, 64'd15);
    put({$urandom, $urandom}, 2'b00, 1'b1, 1'b0, '0);
    chk("se_hi_ber_16", {63'h0, hi_ber}, 64'h1);
    idle(47);
    chk("se_hi_ber_win1_end", {63'h0, hi_ber}, 64'h1);
    idle(63);
    chk("se_hi_ber_win2_late", {63'h0, hi_ber}, 64'h1);
    idle(1);
    chk("se_hi_ber_win2_end", {63'h0, hi_ber}, 64'h0);
    chk("se_err_cnt_16", {56'h0, err_cnt}, 64'd16);
  endtask

  task automatic test_last_cycle_error();
    do_reset();
    repeat (15) put(64'h0, 2'b00, 1'b1, 1'b0, '0);
    idle(48);
    chk("lc_hi_ber_pre", {63'h0, hi_ber}, 64'h0);
    put(64'h0, 2'b11, 1'b1, 1'b0, '0);
    chk("lc_hi_ber_set", {63'h0, hi_ber}, 64'h1);
    chk("lc_err_cnt", {56'h0, err_cnt}, 64'd16);
    idle(1);
    chk("lc_hi_ber_next_win", {63'h0, hi_ber}, 64'h1);
    idle(63);
    chk("lc_hi_ber_clear", {63'h0, hi_ber}, 64'h0);
  endtask

  task automatic test_err_saturation();
    do_reset();
    repeat (260) put(64'h0, 2'b00, 1'b1, 1'b0, '0);
    chk("sat_err_cnt", {56'h0, err_cnt}, 64'd255);
    idle(1);
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (16) put({$urandom, $urandom}, 2'b11, 1'b1, 1'b0, '0);
    chk("ar_pre_hi_ber", {63'h0, hi_ber}, 64'h1);
    chk("ar_pre_synced", {63'h0, descr_synced}, 64'h1);
    #2 rst = 1'b1;
    data_in_valid = 1'b0;
    #1;
    chk("ar_data_out", data_out, 64'h0);
    chk("ar_sync_out", {62'h0, sync_out}, 64'h0);
    chk("ar_valid", {63'h0, data_out_valid}, 64'h0);
    chk("ar_synced", {63'h0, descr_synced}, 64'h0);
    chk("ar_hi_ber", {63'h0, hi_ber}, 64'h0);
    chk("ar_err_cnt", {56'h0, err_cnt}, 64'h0);
    sb.delete();
    msr = '0;
    @(negedge clk);
    rst = 1'b0;
    put(64'h1, 2'b01, 1'b1, 1'b1, 64'h0400_0080_0000_0001);
    put(64'h0, 2'b01, 1'b1, 1'b1, 64'h0);
    idle(2);
  endtask

  initial begin
    msr = '0;
    ssr = '0;
    @(negedge clk);
    test_reset();
    test_zero_block();
    test_single_bit();
    test_round_trip();
    test_sync_errors();
    test_last_cycle_error();
    test_err_saturation();
    test_async_reset();
    chk("final_sb_empty", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pcs_rx_descrambler.md
Name: pcs_rx_descrambler

Overview:
- Receive-side counterpart of the 64-bit 10GBASE-R transmit scrambler.
- Removes the self-synchronous x^58+x^39+1 scrambling from each 64-bit block payload and passes the 2-bit sync header through unchanged.
- Runs a Clause-49-style high-BER monitor over the sync headers.
- Sits between RX block lock / gearbox and the 64b/66b decoder.

Parameters:
- DATA_WIDTH, 64, payload width; only 64 is supported.
- WINDOW_CYCLES, 19531, length of the BER window in clk cycles (125 us at 156.25 MHz).
- BER_THRESH, 16, invalid-header count within one window that asserts hi_ber.

Ports:
- clk  input  1  block clock
- rst  input  1  asynchronous, active-high reset
- data_in  input  64  scrambled payload, bit 0 first on the wire
- sync_in  input  2  sync header for data_in
- data_in_valid  input  1  block qualifier
- data_out  output  64  descrambled payload
- sync_out  output  2  sync header, delayed to align with data_out
- data_out_valid  output  1  output qualifier
- descr_synced  output  1  descrambler state fully loaded from line bits
- hi_ber  output  1  high bit-error-rate indication
- err_cnt  output  8  saturating count of invalid sync headers since reset

Behaviour:
- Reset (async assert, sync release): every output is 0; state register S[57:0]=0; window counter=0; window error counter=0.
- Descramble rule, with X = {data_in, S} (122 bits, X[0] oldest):
  - data_out[i] = data_in[i] ^ X[i+19] ^ X[i], for i=0..63.
  - Equivalently, each output bit is the input bit XOR the scrambled bits 39 and 58 positions earlier.
- State update: on data_in_valid only, S <= data_in[63:6]. S holds when data_in_valid=0.
- Latency: exactly 1 cycle.
  - data_out, sync_out and data_out_valid register together on every clk.
  - data_out_valid = data_in_valid delayed by 1 cycle.
  - data_out and sync_out hold their previous value when data_in_valid=0.
- descr_synced: 0 after reset; set on the cycle the first valid block is registered (58 line bits absorbed); stays 1 until reset.
  - Outputs from that first block are still presented; downstream uses descr_synced to qualify them.
- Sync header check:
  - Valid headers are 2'b01 (data) and 2'b10 (control). 2'b00 and 2'b11 are errors.
  - Checked only when data_in_valid=1.
  - Header errors do not alter descrambling.
- err_cnt: increments by 1 per error; saturates at 255.
- BER window counter: counts every clk cycle from 0 to WINDOW_CYCLES-1, then wraps to 0.
- Window error counter: increments per error; saturates at BER_THRESH.
  - When it reaches BER_THRESH, hi_ber <= 1 on the same registered edge.
- Window end (counter = WINDOW_CYCLES-1):
  - An error on this cycle counts toward the closing window.
  - If the final count (including that error) < BER_THRESH, hi_ber <= 0.
  - If it is >= BER_THRESH, hi_ber stays 1.
  - The window error counter is then cleared to 0 for the next window.
- hi_ber changes only at threshold crossing (set) or at window end (clear).
- Reset mid-operation: everything returns to reset values immediately, including S, descr_synced and hi_ber.

Optional Feature:
- Macro: DESCRAMBLER_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit).
  - While bypass=1, data_out = data_in with the same 1-cycle latency.
  - S continues to update from data_in, so leaving bypass needs no resync.
  - Header check and BER monitor run unchanged.
- When undefined: no bypass port; descrambling is always applied.

Test Plan:
- Reset, then data_in=64'h0, sync_in=2'b01, valid 1 cycle -> next cycle data_out=64'h0, sync_out=2'b01, data_out_valid=1, descr_synced=1, err_cnt=0.
- From reset state, data_in=64'h0000_0000_0000_0001, valid -> data_out=64'h0400_0080_0000_0001. Follow-up block 64'h0 -> data_out=64'h0.
- Round trip: scrambler output fed directly into this block, driving 64'h78d5555555555555, 64'hbbaa554433221100, 64'hcc713b28b2070707 -> after the first block the descrambled stream equals the original payloads in order, with data_out_valid tracking input valid plus 1 cycle.
- Sync errors:
  - 15 blocks with sync_in=2'b11 inside one window (WINDOW_CYCLES=64 in the bench) -> hi_ber stays 0, err_cnt=15.
  - A 16th error in the same window -> hi_ber=1 on the next edge.
  - A following window with 0 errors -> hi_ber=0 right after that window ends.
- Error on the final window cycle making the count 16 -> hi_ber=1 and stays 1 into the next window. Error counter restarts at 0.
- Assert rst asynchronously mid-stream, with hi_ber=1 and descr_synced=1 -> all outputs 0 immediately. The first block after release decodes from S=0.
